// File: rtl/seven_segment_mux_if.sv
// rtl/seven_segment_mux_if.sv - load/count request and display outputs of seven_segment_mux
interface seven_segment_mux_if #(
   parameter int COUNT_W = 7
);
   logic               load;
   logic [COUNT_W-1:0] count;
   logic               busy;
   logic [6:0]         segments;
   logic               digit;

   modport master (
      output load, count,
      input  busy, segments, digit
   );

   modport slave (
      input  load, count,
      output busy, segments, digit
   );
endinterface

// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - binary count to two multiplexed 7-segment digits via subtract-10 engine
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seven_segment_mux #(
   parameter int DIGIT_PERIOD = 100,
   parameter int COUNT_W      = 7
) (
   input logic                clk,
   input logic                reset,
   seven_segment_mux_if.slave bus
);

   localparam int TW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(DIGIT_PERIOD - 1);
   localparam logic [6:0] SEG_DASH = 7'b1000000;

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t             state, state_next;
   logic [COUNT_W-1:0] rem;
   logic [3:0]         wtens;
   logic               ovf;
   logic [3:0]         disp_tens, disp_units;
   logic               disp_dash;
   logic [TW-1:0]      timer;
   logic               digit_q, digit_next;
   logic [6:0]         seg_q, seg_next;
   logic               start, commit, rem_ge10, count_ovf;

   assign count_ovf = (32'(bus.count) > 32'd99);
   assign rem_ge10  = (rem >= COUNT_W'(10));

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.load) state_next = CONVERT;
         CONVERT: if (ovf || !rem_ge10) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Loads arriving in CONVERT are dropped simply because start requires IDLE.
   always_comb begin
      bus.busy = (state == CONVERT);
      start    = (state == IDLE) && bus.load;
      commit   = (state == CONVERT) && (ovf || !rem_ge10);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem        <= '0;
         wtens      <= '0;
         ovf        <= 1'b0;
         disp_tens  <= '0;
         disp_units <= '0;
         disp_dash  <= 1'b0;
      end else if (start) begin
         rem   <= bus.count;
         wtens <= '0;
         ovf   <= count_ovf;
      end else if (commit) begin
         ovf <= 1'b0;
         if (ovf) begin
            disp_dash <= 1'b1;
         end else begin
            disp_tens  <= wtens;
            disp_units <= rem[3:0];
            disp_dash  <= 1'b0;
         end
      end else if (state == CONVERT) begin
         rem   <= rem - COUNT_W'(10);
         wtens <= wtens + 4'd1;
      end
   end

   // Decode from the upcoming digit so segments and digit move on the same edge.
   always_comb begin
      digit_next = (timer == TIMER_LAST) ? ~digit_q : digit_q;
      seg_next   = decode(digit_next ? disp_tens : disp_units);
      if (disp_dash) begin
         seg_next = SEG_DASH;
      end
`ifdef LEADING_ZERO_BLANK_EN
      else if (digit_next && (disp_tens == 4'd0)) begin
         seg_next = 7'b0000000;
      end
`else
      else begin
         seg_next = seg_next;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer   <= '0;
         digit_q <= 1'b0;
         seg_q   <= '0;
      end else begin
         timer   <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
         digit_q <= digit_next;
         seg_q   <= seg_next;
      end
   end

   assign bus.segments = seg_q;
   assign bus.digit    = digit_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb/tb_seven_segment_mux.sv - scoreboard bench for seven_segment_mux against a digit-arithmetic model
module tb_seven_segment_mux;

   localparam int DP = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   seven_segment_mux_if #(.COUNT_W(7)) bus();

   seven_segment_mux #(.DIGIT_PERIOD(DP), .COUNT_W(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat;
      int units;
      int tens;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

`ifdef LEADING_ZERO_BLANK_EN
   localparam int TENS0 = 'h00;
`else
   localparam int TENS0 = 'h3F;
`endif

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   function automatic exp_t model(input int v);
      exp_t e;
      if (v > 99) begin
         e.lat = 1; e.units = 'h40; e.tens = 'h40;
      end else begin
         e.lat   = v / 10 + 1;
         e.units = seg_tab[v % 10];
         e.tens  = (v / 10 == 0) ? TENS0 : seg_tab[v / 10];
      end
      return e;
   endfunction

   // Issue v, optionally a second load o cycles later; o <= latency so it must be dropped.
   task automatic issue(input int v, input int v2, input int o);
      exp_t e;
      e = model(v);
      sb.push_back(e);
      bus.load = 1'b1; bus.count = 7'(v);
      @(negedge clk);
      for (int k = 1; k < o; k++) begin
         bus.load = 1'b0;
         @(negedge clk);
      end
      if (o > 0) begin
         bus.load = 1'b1; bus.count = 7'(v2);
         @(negedge clk);
      end
      bus.load = 1'b0;
      repeat (e.lat + 2 * DP + 4) @(negedge clk);
   endtask

   task automatic reset_seq();
      int d;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_seg", int'(bus.segments), 0);
      chk("rst_digit", int'(bus.digit), 0);
      #1 reset = 1'b0;
      for (int k = 1; k <= 4 * DP; k++) begin
         @(posedge clk); #1;
         d = (k / DP) % 2;
         chk("idle_digit", int'(bus.digit), d);
         chk("idle_seg", int'(bus.segments), d ? TENS0 : 'h3F);
      end
      @(negedge clk);
   endtask

   // Monitor: a busy falling edge is the DUT's response; check its length and the display.
   initial begin
      int   bcnt;
      bit   seen0, seen1;
      exp_t e;
      bcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            if (bcnt > 0 && sb.size() > 0) void'(sb.pop_front());
            bcnt = 0;
         end else if (bus.busy) begin
            bcnt++;
         end else if (bcnt > 0) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("busy_len", bcnt, e.lat);
               @(posedge clk); #1;
               seen0 = 0; seen1 = 0;
               for (int k = 0; k < 2 * DP; k++) begin
                  if (k > 0) begin
                     @(posedge clk); #1;
                  end
                  if (bus.digit) begin
                     seen1 = 1;
                     chk("tens_seg", int'(bus.segments), e.tens);
                  end else begin
                     seen0 = 1;
                     chk("units_seg", int'(bus.segments), e.units);
                  end
               end
               chk("both_phases", int'(seen0 && seen1), 1);
            end
            bcnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int v, v2, o, lat;
      bus.load = 1'b0;
      bus.count = '0;
      repeat (3) @(negedge clk);
      reset_seq();

      issue(42, 0, 0);
      issue(99, 0, 0);
      issue(7, 55, 1);
      issue(120, 0, 0);
      issue(3, 0, 0);
      issue(42, 13, 4);

      for (int i = 0; i < 20; i++) begin
         v   = $urandom_range(0, 127);
         lat = model(v).lat;
         if ($urandom_range(0, 1) == 1) begin
            o  = $urandom_range(1, lat);
            v2 = $urandom_range(0, 127);
         end else begin
            o  = 0;
            v2 = 0;
         end
         issue(v, v2, o);
      end

      issue(125, 0, 0);
      sb.push_back(model(88));
      bus.load = 1'b1; bus.count = 7'd88;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (2) @(negedge clk);
      reset_seq();

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
